// File: rtl/median_pkg.sv
// Shared types and encodings for the median filter core.
// States, output-select codes and the sort-network pair selection rule.
package median_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] SEL_MED = 2'b00;
    localparam logic [1:0] SEL_MIN = 2'b01;
    localparam logic [1:0] SEL_MAX = 2'b10;
    localparam logic [1:0] SEL_RAW = 2'b11;

    // Pair (i,i+1) is compared on even passes when i is even, on odd passes when i is odd.
    function automatic logic pair_active(input int unsigned lower_idx, input logic odd_pass);
        return (lower_idx[0] == odd_pass);
    endfunction

endpackage

// File: rtl/median_filter_core_if.sv
// Register/handshake bundle for median_filter_core.
// The master drives writes, sort requests and output selection; the core answers.
interface median_filter_core_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 5
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              wr_enable;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] data_in;
    logic              start;
    logic [1:0]        out_select;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] data_out;

    modport master (
        output wr_enable, reg_addr, data_in, start, out_select,
        input  busy, done, data_out
    );

    modport slave (
        input  wr_enable, reg_addr, data_in, start, out_select,
        output busy, done, data_out
    );

endinterface

// File: rtl/median_cswap.sv
// Combinational compare-swap element of the odd-even transposition network.
// Equal inputs pass straight through, so the sort is stable.
module median_cswap #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] hi
);

    always_comb begin
        if (a > b) begin
            lo = b;
            hi = a;
        end else begin
            lo = a;
            hi = b;
        end
    end

endmodule

// File: rtl/median_filter_core.sv
// Windowed median/min/max engine: DEPTH-entry sample window, snapshot sorted by
// one odd-even transposition pass per cycle, results held until the next sort.
module median_filter_core
    import median_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 5
) (
    input  logic clk,
    input  logic rst,
    median_filter_core_if.slave bus
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PASS_W = $clog2(DEPTH);

    state_t            state;
    state_t            state_next;
    logic [PASS_W-1:0] pass_cnt;
    logic              sort_go;
    logic              last_pass;
    logic              addr_ok;

    logic [DATA_W-1:0] window [DEPTH];
    logic [DATA_W-1:0] s      [DEPTH];
    logic [DATA_W-1:0] s_pass [DEPTH];
    logic [DATA_W-1:0] lo     [DEPTH-1];
    logic [DATA_W-1:0] hi     [DEPTH-1];
    logic [DATA_W-1:0] res_min;
    logic [DATA_W-1:0] res_med;
    logic [DATA_W-1:0] res_max;

    // DEPTH is odd, so it is never a power of two and always fits in ADDR_W bits.
    assign addr_ok   = (bus.reg_addr < ADDR_W'(DEPTH));
    assign last_pass = (pass_cnt == PASS_W'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        sort_go    = 1'b0;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = SORT;
                    sort_go    = 1'b1;
                end
            end
            SORT: begin
                bus.busy = 1'b1;
                if (last_pass) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.busy   = 1'b1;
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    for (genvar g = 0; g < DEPTH - 1; g++) begin : g_cswap
        median_cswap #(.DATA_W(DATA_W)) u_cswap (
            .a  (s[g]),
            .b  (s[g+1]),
            .lo (lo[g]),
            .hi (hi[g])
        );
    end

    // Pairs within one phase never overlap, so committing them in sequence is safe.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            s_pass[i] = s[i];
        end
        for (int unsigned i = 0; i < DEPTH - 1; i++) begin
            if (pair_active(i, pass_cnt[0])) begin
                s_pass[i]   = lo[i];
                s_pass[i+1] = hi[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pass_cnt <= '0;
            res_min  <= '0;
            res_med  <= '0;
            res_max  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                window[i] <= '0;
                s[i]      <= '0;
            end
        end else begin
            if (state == IDLE && bus.wr_enable && addr_ok) begin
                window[bus.reg_addr] <= bus.data_in;
            end
            // Snapshot reads the pre-edge window, so a same-cycle write is not seen.
            if (sort_go) begin
                pass_cnt <= '0;
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    s[i] <= window[i];
                end
            end else if (state == SORT) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    s[i] <= s_pass[i];
                end
                if (last_pass) begin
                    res_min <= s_pass[0];
                    res_med <= s_pass[(DEPTH-1)/2];
                    res_max <= s_pass[DEPTH-1];
                end else begin
                    pass_cnt <= pass_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.data_out = '0;
        case (bus.out_select)
            SEL_MED: bus.data_out = res_med;
            SEL_MIN: bus.data_out = res_min;
            SEL_MAX: bus.data_out = res_max;
            SEL_RAW: bus.data_out = addr_ok ? window[bus.reg_addr] : '0;
            default: bus.data_out = '0;
        endcase
    end

endmodule

// File: tb/tb_median_filter_core.sv
// Scenario bench for median_filter_core (DATA_W=8, DEPTH=5) with a result scoreboard.
module tb_median_filter_core;
    import median_pkg::*;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 5;

    typedef struct {
        logic [7:0] med;
        logic [7:0] mn;
        logic [7:0] mx;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    median_filter_core_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    median_filter_core #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    res_t       sb_q [$];
    logic [7:0] model_win [DEPTH];
    int         n_cmp = 0;
    int         n_err = 0;

    function automatic res_t model_sort();
        logic [7:0] v [DEPTH];
        logic [7:0] t;
        res_t r;
        for (int i = 0; i < DEPTH; i++) v[i] = model_win[i];
        for (int i = 1; i < DEPTH; i++) begin
            for (int j = i; j > 0; j--) begin
                if (v[j-1] > v[j]) begin
                    t = v[j]; v[j] = v[j-1]; v[j-1] = t;
                end
            end
        end
        r.mn  = v[0];
        r.med = v[(DEPTH-1)/2];
        r.mx  = v[DEPTH-1];
        return r;
    endfunction

    task automatic write_word(input int addr, input logic [7:0] d);
        @(negedge clk);
        bus.wr_enable = 1'b1;
        bus.reg_addr  = 3'(addr);
        bus.data_in   = d;
        if (addr < DEPTH) model_win[addr] = d;
        @(negedge clk);
        bus.wr_enable = 1'b0;
    endtask

    // Launches a sort, optionally with a same-cycle write and a poke while busy,
    // and observes 14 cycles of the response.
    task automatic run_sort(input bit wr, input int waddr, input logic [7:0] wdata,
                            input bit poke, output res_t obs, output int done_cyc,
                            output int n_done, output int busy_rise, output int busy_fall);
        obs.med = '0; obs.mn = '0; obs.mx = '0;
        done_cyc = -1; n_done = 0; busy_rise = -1; busy_fall = -1;
        @(negedge clk);
        bus.start = 1'b1;
        if (wr) begin
            bus.wr_enable = 1'b1;
            bus.reg_addr  = 3'(waddr);
            bus.data_in   = wdata;
        end
        sb_q.push_back(model_sort());
        if (wr && waddr < DEPTH) model_win[waddr] = wdata;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.start     = 1'b0;
                bus.wr_enable = 1'b0;
            end
            if (bus.busy === 1'b1 && busy_rise < 0) busy_rise = c;
            if (bus.busy === 1'b0 && busy_rise >= 0 && busy_fall < 0) busy_fall = c;
            if (bus.done === 1'b1) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    bus.out_select = SEL_MED; #1 obs.med = bus.data_out;
                    bus.out_select = SEL_MIN; #1 obs.mn  = bus.data_out;
                    bus.out_select = SEL_MAX; #1 obs.mx  = bus.data_out;
                    bus.out_select = SEL_MED;
                end
            end
            if (poke && c == 2) begin
                bus.wr_enable = 1'b1;
                bus.reg_addr  = 3'd1;
                bus.data_in   = 8'd0;
                bus.start     = 1'b1;
            end
            if (poke && c == 3) begin
                bus.wr_enable = 1'b0;
                bus.start     = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        bus.wr_enable = 0; bus.reg_addr = '0; bus.data_in = '0;
        bus.start = 0; bus.out_select = SEL_MED;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_win[i] = '0;
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_cmp++;
        if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        for (int sel = 0; sel < 4; sel++) begin
            bus.out_select = 2'(sel);
            #1;
            n_cmp++;
            if (bus.data_out !== 8'd0) begin
                n_err++; $display("FAIL reset_data_out sel=%0d: got %0d expected 0", sel, bus.data_out);
            end
        end
        bus.out_select = SEL_MED;
    endtask

    task automatic test_sort_patterns();
        logic [7:0] pats [3][DEPTH];
        res_t obs, exp;
        int dc, nd, br, bf;
        pats[0] = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd5};
        pats[1] = '{8'd200, 8'd150, 8'd100, 8'd50, 8'd0};
        pats[2] = '{8'd4, 8'd4, 8'd4, 8'd2, 8'd8};
        for (int p = 0; p < 3; p++) begin
            for (int a = 0; a < DEPTH; a++) write_word(a, pats[p][a]);
            run_sort(1'b0, 0, 8'd0, 1'b0, obs, dc, nd, br, bf);
            exp = sb_q.pop_front();
            n_cmp++;
            if (dc !== 6) begin n_err++; $display("FAIL pat%0d_done_cycle: got %0d expected 6", p, dc); end
            n_cmp++;
            if (nd !== 1) begin n_err++; $display("FAIL pat%0d_done_count: got %0d expected 1", p, nd); end
            n_cmp++;
            if (br !== 1) begin n_err++; $display("FAIL pat%0d_busy_rise: got %0d expected 1", p, br); end
            n_cmp++;
            if (bf !== 7) begin n_err++; $display("FAIL pat%0d_busy_fall: got %0d expected 7", p, bf); end
            n_cmp++;
            if (obs.med !== exp.med) begin n_err++; $display("FAIL pat%0d_median: got %0d expected %0d", p, obs.med, exp.med); end
            n_cmp++;
            if (obs.mn !== exp.mn) begin n_err++; $display("FAIL pat%0d_min: got %0d expected %0d", p, obs.mn, exp.mn); end
            n_cmp++;
            if (obs.mx !== exp.mx) begin n_err++; $display("FAIL pat%0d_max: got %0d expected %0d", p, obs.mx, exp.mx); end
            if (p == 0) begin
                bus.out_select = SEL_RAW; bus.reg_addr = 3'd2; #1;
                n_cmp++;
                if (bus.data_out !== 8'd7) begin n_err++; $display("FAIL raw_addr2: got %0d expected 7", bus.data_out); end
                bus.out_select = SEL_MIN; #1;
                n_cmp++;
                if (bus.data_out !== exp.mn) begin n_err++; $display("FAIL min_held: got %0d expected %0d", bus.data_out, exp.mn); end
                bus.out_select = SEL_MED;
            end
        end
    endtask

    task automatic test_same_cycle_write();
        res_t obs, exp;
        int dc, nd, br, bf;
        logic [7:0] base [DEPTH];
        base = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd5};
        for (int a = 0; a < DEPTH; a++) write_word(a, base[a]);
        run_sort(1'b1, 0, 8'd255, 1'b0, obs, dc, nd, br, bf);
        exp = sb_q.pop_front();
        n_cmp++;
        if (obs.med !== exp.med) begin n_err++; $display("FAIL same_cycle_median: got %0d expected %0d", obs.med, exp.med); end
        n_cmp++;
        if (obs.mx !== exp.mx) begin n_err++; $display("FAIL same_cycle_max: got %0d expected %0d", obs.mx, exp.mx); end
        bus.out_select = SEL_RAW; bus.reg_addr = 3'd0; #1;
        n_cmp++;
        if (bus.data_out !== 8'd255) begin n_err++; $display("FAIL same_cycle_raw0: got %0d expected 255", bus.data_out); end
        bus.out_select = SEL_MED;
    endtask

    task automatic test_busy_ignored();
        res_t obs, exp;
        int dc, nd, br, bf;
        run_sort(1'b0, 0, 8'd0, 1'b1, obs, dc, nd, br, bf);
        exp = sb_q.pop_front();
        n_cmp++;
        if (nd !== 1) begin n_err++; $display("FAIL busy_done_count: got %0d expected 1", nd); end
        n_cmp++;
        if (obs.med !== exp.med) begin n_err++; $display("FAIL busy_median: got %0d expected %0d", obs.med, exp.med); end
        bus.out_select = SEL_RAW; bus.reg_addr = 3'd1; #1;
        n_cmp++;
        if (bus.data_out !== model_win[1]) begin
            n_err++; $display("FAIL busy_raw1: got %0d expected %0d", bus.data_out, model_win[1]);
        end
        bus.out_select = SEL_MED;
    endtask

    task automatic test_bad_addr();
        write_word(6, 8'hAA);
        bus.out_select = SEL_RAW; bus.reg_addr = 3'd6; #1;
        n_cmp++;
        if (bus.data_out !== 8'd0) begin n_err++; $display("FAIL bad_addr_raw6: got %0d expected 0", bus.data_out); end
        for (int a = 0; a < DEPTH; a++) begin
            bus.reg_addr = 3'(a); #1;
            n_cmp++;
            if (bus.data_out !== model_win[a]) begin
                n_err++; $display("FAIL bad_addr_win%0d: got %0d expected %0d", a, bus.data_out, model_win[a]);
            end
        end
        bus.out_select = SEL_MED;
    endtask

    task automatic test_reset_abort();
        res_t obs, exp;
        int dc, nd, br, bf, spurious;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) model_win[i] = '0;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
        for (int sel = 0; sel < 4; sel++) begin
            bus.out_select = 2'(sel); bus.reg_addr = 3'd0; #1;
            n_cmp++;
            if (bus.data_out !== 8'd0) begin
                n_err++; $display("FAIL abort_data_out sel=%0d: got %0d expected 0", sel, bus.data_out);
            end
        end
        bus.out_select = SEL_MED;
        spurious = 0;
        for (int c = 0; c < 8; c++) begin
            if (bus.done === 1'b1) spurious++;
            @(negedge clk);
        end
        n_cmp++;
        if (spurious !== 0) begin n_err++; $display("FAIL abort_no_done: got %0d expected 0", spurious); end
        run_sort(1'b0, 0, 8'd0, 1'b0, obs, dc, nd, br, bf);
        exp = sb_q.pop_front();
        n_cmp++;
        if (dc !== 6) begin n_err++; $display("FAIL post_abort_done_cycle: got %0d expected 6", dc); end
        n_cmp++;
        if (obs.med !== exp.med) begin n_err++; $display("FAIL post_abort_median: got %0d expected %0d", obs.med, exp.med); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sort_patterns();
        test_same_cycle_write();
        test_busy_ignored();
        test_bad_addr();
        test_reset_abort();
        n_cmp++;
        if (sb_q.size() !== 0) begin n_err++; $display("FAIL scoreboard_leftover: got %0d expected 0", sb_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/median_filter_core.md
# median_filter_core

Parametrised successor to the fixed 8-bit median processor. It holds a DEPTH-entry sample window written through a register-address port and sorts a snapshot of it on request with a multi-cycle odd-even transposition sort. It exposes median, minimum, maximum or a raw window entry on a selectable output. It sits behind the input pad cells, alongside the shift-register and LFSR blocks, sharing their clock and reset.

## Interface
- DATA_W, 8, sample width in bits (unsigned), 2..16
- DEPTH, 5, window length; must be odd, 3..15
- ADDR_W, $clog2(DEPTH), derived; not to be overridden
- clk  input  1  single clock, rising edge
- rst  input  1  reset; synchronous, active-high
- wr_enable  input  1  write data_in to window[reg_addr]
- reg_addr  input  ADDR_W  window write / raw-read address
- data_in  input  DATA_W  sample to write
- start  input  1  request sort of current window
- out_select  input  2  00 median, 01 min, 10 max, 11 raw window[reg_addr]
- busy  output  1  sort in progress (SORT or DONE)
- done  output  1  one-cycle pulse, results valid
- data_out  output  DATA_W  selected result

## Operation
- FSM states: IDLE, SORT, DONE.
- IDLE:
  - wr_enable writes window[reg_addr] at the edge.
  - reg_addr >= DEPTH: write is ignored.
  - start moves the FSM to SORT and snapshots window into sort array s[0..DEPTH-1].
  - Pass counter is cleared to 0.
- SORT: one compare-swap pass per cycle.
  - Even pass count: pairs (0,1),(2,3),…
  - Odd pass count: pairs (1,2),(3,4),…
  - Swap only if s[i] > s[i+1], so equal values are not swapped.
  - The edge that completes pass DEPTH-1 latches min=s[0], med=s[(DEPTH-1)/2], max=s[DEPTH-1] from the post-pass values and moves the FSM to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Writes and starts while busy=1 are ignored (dropped, not queued).
- start and wr_enable in the same IDLE cycle: both take effect. The snapshot uses pre-write window contents; the write lands in window.
- data_out is a combinational mux of out_select over the registered min/med/max and window[reg_addr]. In raw mode, reg_addr >= DEPTH gives 0.
- Result registers hold until the next DONE. Window contents persist across sorts.
- Comparison is unsigned full DATA_W. There is no arithmetic, so there is no width growth.

## Timing
- Reset (rst high at an edge):
  - state=IDLE, pass counter=0.
  - window, s, min/med/max all 0.
  - busy=0, done=0, data_out=0.
- start sampled at edge 0:
  - busy=1 from cycle 1.
  - SORT occupies cycles 1..DEPTH.
  - done=1 in cycle DEPTH+1, with results on data_out in that same cycle.
  - busy=0 and IDLE from cycle DEPTH+2.
- Throughput is one sort per DEPTH+2 cycles. start is accepted again in the cycle busy falls.
- rst during SORT or DONE aborts at that edge: all outputs take reset values, no done pulse, previous results are lost (zeroed).
- wr_enable has single-cycle write latency. A raw readback of the same address shows the new value from the next cycle.

## Structure
- Package median_pkg:
  - state enum (IDLE/SORT/DONE)
  - out_select encodings SEL_MED=2'b00, SEL_MIN=2'b01, SEL_MAX=2'b10, SEL_RAW=2'b11
- Sub-module median_cswap (parameter DATA_W):
  - combinational compare-swap, inputs a,b, outputs lo,hi
  - instantiated DEPTH-1 times via generate
  - a per-pass phase enable selects which pair outputs are committed
- Top contains the FSM, pass counter, window registers, sort array, result registers and the output mux.

## Test plan
- Reset then idle, all selects -> data_out=0, busy=0, done=0.
- DEPTH=5, DATA_W=8; write 9,3,7,1,5 to addr 0..4; pulse start -> done in cycle 6 exactly once; median 5, min 1, max 9; raw addr 2 = 7.
- Worst case: window 200,150,100,50,0 -> median 100, min 0, max 200 after exactly 5 passes. Duplicates 4,4,4,2,8 -> median 4, min 2, max 8.
- wr_enable addr 0 = 255 and start in the same cycle over window 9,3,7,1,5 -> median 5 (pre-write snapshot); raw addr 0 = 255 afterwards.
- During busy: write addr 1 = 0 and pulse start -> both ignored; window[1] unchanged, only one done pulse. Write to addr 6 while IDLE -> no window change; raw addr 6 = 0.
- rst asserted in SORT cycle 3 -> no done pulse, all outputs 0. A new sort afterwards on the zeroed window -> median 0.
